riscv_multicycle_controller: RTL
================================

# riscv_multicycle_controller

Multi-cycle control unit for the RV32I core, replacing the single-cycle controller. It sequences each instruction through a Moore-style state machine over a shared instruction/data memory with wait-state handshake. It drives the multi-cycle datapath's enables and mux selects, flags unsupported encodings, and counts retired instructions. It sits beside the multi-cycle datapath under the CPU top, taking `op`/`func3`/`func7`/`zero`/`neg` back from it.

## Interface
- `ALU_CTRL_W`, 3: width of `ALUControl`; must be ≥3, upper bits driven 0.
- `MEM_WAIT_EN`, 1: 1 = honour `mem_ready`; 0 = every memory access completes in one cycle (`mem_ready` ignored).
- `CNT_W`, 32: width of `instret`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  instruction opcode.
- `func3`  in  3  instruction func3.
- `func7`  in  7  instruction func7.
- `zero`  in  1  ALU result == 0.
- `neg`  in  1  ALU result sign bit of a signed subtract.
- `mem_ready`  in  1  memory access completes this cycle.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `AdrSrc`  out  1 each.
- `ResultSrc`  out  2  00 ALUOut, 01 read data, 10 ALU result, 11 immediate.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  00 rs2, 01 immediate, 10 constant 4.
- `ImmSrc`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl`  out  `ALU_CTRL_W`  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- `illegal_op`  out  1  one-cycle pulse on an unsupported encoding.
- `instr_done`  out  1  one-cycle pulse in each instruction's last cycle.
- `instret`  out  `CNT_W`  retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR_LINK, LUI.
- Any output not listed for a state is 0.
- **FETCH:** `AdrSrc`=0, A=00, B=10, add, `ResultSrc`=10. `IRWrite` and `PCWrite` assert only when the access completes (`mem_ready`, or always if `MEM_WAIT_EN`=0). Otherwise the state holds. On completion → DECODE.
- **DECODE:** A=01, B=01, add; `ImmSrc` per opcode (branch target into ALUOut). Next state by `op`:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → FETCH with `illegal_op`=1.
- Illegal encodings are also detected in DECODE: R/I func3 001 or 101; branch func3 110 or 111; load/store func3 ≠ 010. Each takes the same FETCH + `illegal_op` path.
- **MEMADR:** A=10, B=01, add, `ImmSrc`=I for loads, S for stores. → MEMREAD (load) or MEMWRITE (store).
- **MEMREAD:** `AdrSrc`=1; hold until completion, then → MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1.
- **MEMWRITE:** `AdrSrc`=1, `MemWrite`=1, held until completion; `instr_done` on the completion cycle.
- **EXECR / EXECI:** A=10, B=00 (R) or 01 (I).
  - ALU op from func3: 000 → add, or sub when R-type with func7[5]=1 (addi is always add); 111 → and; 110 → or; 100 → xor; 010 → slt; 011 → sltu.
  - → ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1.
- **BRANCH:** A=10, B=00, sub, `ResultSrc`=00, `ImmSrc`=B. `PCWrite` = taken:
  - beq (000): `zero`
  - bne (001): !`zero`
  - blt (100): `neg`
  - bge (101): !`neg`
- **JAL:** A=01, B=10, add, `ResultSrc`=00, `PCWrite`=1. → ALUWB, which writes OldPC+4.
- **JALR:** A=10, B=01, add, `ImmSrc`=I, `ResultSrc`=10, `PCWrite`=1. → JALR_LINK.
- **JALR_LINK:** A=01, B=10, add, `ResultSrc`=10, `RegWrite`=1. rd==rs1 is safe because rs1 was consumed in JALR.
- **LUI:** `ImmSrc`=U, `ResultSrc`=11, `RegWrite`=1.
- Terminal states: MEMWB, MEMWRITE-complete, ALUWB, BRANCH, JALR_LINK, LUI. Each pulses `instr_done` and → FETCH.
- `instret` increments by 1 on each `instr_done`. It wraps modulo 2^`CNT_W`. It does not count illegal instructions.

## Timing
- Reset (asynchronous):
  - state=FETCH, `instret`=0.
  - While `rst_n`=0, `PCWrite`/`IRWrite`/`MemWrite`/`RegWrite`/`illegal_op`/`instr_done` are forced to 0.
  - Reset mid-instruction abandons it with no writes.
- Cycles with zero wait states:
  - lw 5.
  - sw, R, I, jal, jalr 4 each.
  - beq/bne/blt/bge, lui 3.
  - illegal 2.
- Each memory wait cycle adds 1; outputs stay stable while waiting.
- `mem_ready` high outside FETCH/MEMREAD/MEMWRITE is ignored.
- The next FETCH starts the cycle after `instr_done`; there is no idle cycle.

## Test plan
- Reset then `add` (op 0110011, func3 000, func7 0), `mem_ready`=1 → states F, D, EXECR, ALUWB; `ALUControl`=000; `RegWrite` only in cycle 4; `instret`=1.
- `sub` (func7 0100000) → `ALUControl`=001 in EXECR; `addi` with func7 bits set → still 000.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total; `IRWrite` one cycle only; `RegWrite` with `ResultSrc`=01.
- sw held 2 wait cycles → `MemWrite`=1 for 3 cycles; no `RegWrite`.
- Branches:
  - beq with `zero`=1 → `PCWrite`=1 in BRANCH.
  - bne with `zero`=1 → `PCWrite`=0.
  - bge with `neg`=0 → 1.
  - op 0000000 → `illegal_op` pulse after 2 cycles, `instret` unchanged.
- jalr → JALR `PCWrite`=1, JALR_LINK `RegWrite`=1 with A=01/B=10. Also assert `rst_n` low during JALR → immediate FETCH and all enables 0.

Source files
------------

// File: rtl/riscv_multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and the datapath/memory side.
// master = controller, slave = datapath and memory.
interface riscv_multicycle_controller_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 32
) ();
  logic [6:0]            op;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic                  zero;
  logic                  neg;
  logic                  mem_ready;
  logic                  PCWrite;
  logic                  IRWrite;
  logic                  MemWrite;
  logic                  RegWrite;
  logic                  AdrSrc;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [2:0]            ImmSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  illegal_op;
  logic                  instr_done;
  logic [CNT_W-1:0]      instret;

  modport master (
    input  op, func3, func7, zero, neg, mem_ready,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, instr_done, instret
  );

  modport slave (
    output op, func3, func7, zero, neg, mem_ready,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, instr_done, instret
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Moore-style multi-cycle RV32I control unit over a shared wait-state memory.
// Write enables are forced low while rst_n is asserted; instret counts retired instructions.
module riscv_multicycle_controller #(
  parameter int ALU_CTRL_W  = 3,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  riscv_multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  function automatic logic [2:0] imm_for_op(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_for_op = 3'b001;
      OP_BRANCH: imm_for_op = 3'b010;
      OP_JAL:    imm_for_op = 3'b011;
      OP_LUI:    imm_for_op = 3'b100;
      default:   imm_for_op = 3'b000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_IMM:              is_illegal = (f3 == 3'b001) || (f3 == 3'b101);
      OP_BRANCH:                 is_illegal = (f3 == 3'b110) || (f3 == 3'b111);
      OP_LOAD, OP_STORE:         is_illegal = (f3 != 3'b010);
      OP_JAL, OP_JALR, OP_LUI:   is_illegal = 1'b0;
      default:                   is_illegal = 1'b1;
    endcase
  endfunction

  // sub only for R-type with func7[5]; immediate forms always add
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7_5, input logic r_type);
    case (f3)
      3'b000:  alu_decode = (r_type && f7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = 3'b010;
      3'b110:  alu_decode = 3'b011;
      3'b100:  alu_decode = 3'b100;
      3'b010:  alu_decode = 3'b101;
      3'b011:  alu_decode = 3'b110;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = !z;
      3'b100:  branch_taken = n;
      3'b101:  branch_taken = !n;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_done_s;
  logic             pc_write_s, ir_write_s, mem_write_s, reg_write_s, adr_src_s;
  logic             illegal_s, done_s;
  logic [1:0]       result_src_s, src_a_s, src_b_s;
  logic [2:0]       imm_src_s, alu_s;

  assign mem_done_s = !MEM_WAIT_EN || ctrl.mem_ready;

  // Next-state and per-state control outputs
  always_comb begin
    state_d      = state_q;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    illegal_s    = 1'b0;
    done_s       = 1'b0;
    result_src_s = 2'b00;
    src_a_s      = 2'b00;
    src_b_s      = 2'b00;
    imm_src_s    = 3'b000;
    alu_s        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        src_b_s      = 2'b10;
        result_src_s = 2'b10;
        if (mem_done_s) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        src_a_s   = 2'b01;
        src_b_s   = 2'b01;
        imm_src_s = imm_for_op(ctrl.op);
        if (is_illegal(ctrl.op, ctrl.func3)) begin
          illegal_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
          case (ctrl.op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_IMM:            state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        if (ctrl.op == OP_STORE) begin
          imm_src_s = 3'b001;
          state_d   = S_MEMWRITE;
        end else begin
          imm_src_s = 3'b000;
          state_d   = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (mem_done_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_done_s) begin
          done_s  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        src_a_s = 2'b10;
        alu_s   = alu_decode(ctrl.func3, ctrl.func7[5], 1'b1);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        alu_s   = alu_decode(ctrl.func3, ctrl.func7[5], 1'b0);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s    = 2'b10;
        alu_s      = ALU_SUB;
        imm_src_s  = 3'b010;
        pc_write_s = branch_taken(ctrl.func3, ctrl.zero, ctrl.neg);
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      // PC <- branch target latched in DECODE; ALUOut <- OldPC+4 for ALUWB
      S_JAL: begin
        src_a_s    = 2'b01;
        src_b_s    = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b01;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
        state_d      = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a_s      = 2'b01;
        src_b_s      = 2'b10;
        result_src_s = 2'b10;
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
        state_d      = S_FETCH;
      end
      S_LUI: begin
        imm_src_s    = 3'b100;
        result_src_s = 2'b11;
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_comb begin
    if (done_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign ctrl.PCWrite    = pc_write_s  & rst_n;
  assign ctrl.IRWrite    = ir_write_s  & rst_n;
  assign ctrl.MemWrite   = mem_write_s & rst_n;
  assign ctrl.RegWrite   = reg_write_s & rst_n;
  assign ctrl.illegal_op = illegal_s   & rst_n;
  assign ctrl.instr_done = done_s      & rst_n;
  assign ctrl.AdrSrc     = adr_src_s;
  assign ctrl.ResultSrc  = result_src_s;
  assign ctrl.ALUSrcA    = src_a_s;
  assign ctrl.ALUSrcB    = src_b_s;
  assign ctrl.ImmSrc     = imm_src_s;
  assign ctrl.ALUControl = ALU_CTRL_W'(alu_s);
  assign ctrl.instret    = instret_q;

endmodule
